serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing a − b − bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the ripple full-adder datapath: a parallel operand load, WIDTH serial cycles, then a registered result with borrow and signed-overflow flags. Control blocks in the arithmetic unit drive it with a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high in RUN and DONE states
- done  output  1  single-cycle pulse, result valid
- diff  output  WIDTH  registered difference, held until next accepted start
- bout  output  1  final borrow (1 ⇔ a < b + bin, unsigned)
- ovf  output  1  signed overflow of a − b − bin

## Operation
- Reset (async, rst_n low): state IDLE; busy, done, bout, ovf = 0; diff = 0; shift registers, borrow FF, bit counter = 0. Takes effect immediately, including mid-RUN; the operation in flight is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → load a, b into shift registers, borrow FF ← bin, counter ← 0, clear diff/bout/ovf, go RUN. start=0 → stay.
  - RUN: each cycle compute on LSBs ai, bi, borrow br: d = ai ^ bi ^ br; bo = (~ai & bi) | (~(ai ^ bi) & br). Shift d into the MSB of the result register (right shift), shift a and b right, borrow FF ← bo, counter +1. After the WIDTH-th bit (counter = WIDTH−1) go DONE.
  - DONE: done=1 for exactly this cycle; diff, bout, ovf already valid. Unconditionally go IDLE.
- bout = borrow FF after the MSB step.
- ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]) using captured operand MSBs (stored separately at load). bin does not alter the rule.
- Counter width $clog2(WIDTH); no wrap beyond WIDTH−1.
- start while busy: ignored, not queued. start in the DONE cycle: ignored; a start held high into the following IDLE cycle is accepted.
- a, b, bin changes after the accepting edge have no effect.

## Timing
- Accepting edge = cycle 0. RUN occupies cycles 1..WIDTH; done high cycle WIDTH+1; IDLE at WIDTH+2. Earliest back-to-back start accepted at edge WIDTH+2; total period WIDTH+2 cycles.
- busy rises in cycle 1, falls when done falls.
- diff/bout/ovf are registered outputs, stable from the done cycle until the cycle after the next accepted start (cleared on load).
- No combinational path from inputs to outputs.

## Test plan
- a=0x35, b=0x12, bin=0, start at cycle 0 → done only at cycle 9, diff=0x23, bout=0, ovf=0; busy high cycles 1–9.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1; then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0, ovf=0; a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- start held high continuously with changing a/b → accepted only at cycles 0, 10, 20…; each result matches the operands present at its accepting edge; exactly one done per operation.
- rst_n low at cycle 4 of a run → all outputs 0 immediately, no done; after release, a=0x09, b=0x03 → diff=0x06 at the expected done cycle.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, using one
// full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              cell_d;
  logic              cell_bo;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    cell_d  = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    cell_bo = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          ovf_d    = 1'b0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        diff_d   = {cell_d, diff_q[WIDTH-1:1]};
        borrow_d = cell_bo;
        if (cnt_q == LastCnt) begin
          // cell_d here is the result MSB.
          bout_d  = cell_bo;
          ovf_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a scoreboard of expected results, filled when
// a start is predicted to be accepted and drained when done pulses.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           done_at;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t         sb[$];
  int           n_vec;
  int           n_err;
  int           nc;
  int           next_free;
  int           acc_at;
  logic [W-1:0] held;
  logic         held_ok;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, nc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi, input int at);
    exp_t       e;
    logic [W:0] full;
    int         sa;
    int         sbv;
    int         sd;
    full = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    sa   = $signed(av);
    sbv  = $signed(bv);
    sd   = sa - sbv - int'(bi);
    e.diff    = full[W-1:0];
    e.bout    = full[W];
    e.ovf     = (sd > 127) || (sd < -128);
    e.done_at = at;
    return e;
  endfunction

  // Advance to the next falling edge and check everything visible in that cycle.
  task automatic tick();
    exp_t e;
    logic exp_busy;
    @(negedge clk);
    nc++;
    exp_busy = (acc_at >= 0) && (nc > acc_at) && (nc <= acc_at + W + 1);
    check_eq("busy", busy, exp_busy);
    if (acc_at >= 0 && nc == acc_at + 1) begin
      check_eq("diff_clear_on_load", diff, 0);
      check_eq("flags_clear_on_load", {bout, ovf}, 0);
    end
    if (sb.size() > 0 && nc > sb[0].done_at) begin
      check_eq("done_missing", 0, 1);
      void'(sb.pop_front());
    end
    if (done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("done_cycle", nc, e.done_at);
        check_eq("diff", diff, e.diff);
        check_eq("bout", bout, e.bout);
        check_eq("ovf", ovf, e.ovf);
        held    = e.diff;
        held_ok = 1'b1;
      end
    end else if (!busy && held_ok) begin
      check_eq("diff_held", diff, held);
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bi);
    start = s;
    a     = av;
    b     = bv;
    bin   = bi;
    if (s && rst_n && nc >= next_free) begin
      sb.push_back(model(av, bv, bi, nc + W + 1));
      acc_at    = nc;
      next_free = nc + W + 2;
    end
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    drive(1'b1, av, bv, bi);
    tick();
    for (int i = 0; i < W + 3; i++) begin
      drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
      tick();
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    nc        = 0;
    next_free = 0;
    acc_at    = -100;
    held      = '0;
    held_ok   = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    tick();
    tick();
    check_eq("reset_done", done, 0);
    check_eq("reset_outputs", {diff, bout, ovf}, 0);
    rst_n = 1'b1;
    tick();

    op(8'h35, 8'h12, 1'b0);
    op(8'h00, 8'h01, 1'b0);
    op(8'h80, 8'h01, 1'b0);
    op(8'h7F, 8'hFF, 1'b0);
    op(8'h10, 8'h0F, 1'b1);
    op(8'h00, 8'h00, 1'b1);
    op(8'h80, 8'h00, 1'b1);
    op(8'h7F, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) op(W'($urandom), W'($urandom), 1'($urandom));

    // start held high with fresh operands every cycle
    for (int i = 0; i < 3 * (W + 2); i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
      tick();
    end
    for (int i = 0; i < W + 3; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      tick();
    end

    // reset in cycle 4 of a run
    drive(1'b1, 8'h5A, 8'h33, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_busy_done", {busy, done}, 0);
    check_eq("async_reset_outputs", {diff, bout, ovf}, 0);
    sb.delete();
    acc_at    = -100;
    next_free = 0;
    held_ok   = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) tick();
    op(8'h09, 8'h03, 1'b0);
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
